// File: rtl/cache_nway_ctrl_if.sv
// Core request/response and refill handshake bundle for cache_nway_ctrl.
// master = requester/memory side, slave = cache controller.
interface cache_nway_ctrl_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_hit;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (
    output req_valid, req_addr, mem_ack, mem_data,
    input  req_ready, resp_valid, resp_data, resp_hit, mem_req, mem_addr
  );

  modport slave (
    input  req_valid, req_addr, mem_ack, mem_data,
    output req_ready, resp_valid, resp_data, resp_hit, mem_req, mem_addr
  );
endinterface

// File: rtl/cache_nway_ctrl.sv
// N-way set-associative read cache, true-LRU; hit response 2 cycles after accept, miss waits on mem_ack.
// req_ready drops for the whole transaction; optional hit/miss counters under CACHE_STATS_EN.
module cache_nway_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 16,
  parameter int CACHE_SIZE = 256,
  parameter int NUM_WAYS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  cache_nway_ctrl_if.slave  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);
  localparam int OFF_W    = $clog2(BLOCK_SIZE);
  localparam int NUM_SETS = CACHE_SIZE / (BLOCK_SIZE * NUM_WAYS);
  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int TAG_W    = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int AGE_W    = $clog2(NUM_WAYS);
  localparam int LINE_W   = ADDR_WIDTH - OFF_W;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_RESP} state_t;

  state_t                r_state;
  logic [LINE_W-1:0]     r_line;
  logic                  r_valid [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]      r_tag   [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] r_data  [NUM_SETS][NUM_WAYS];
  logic [AGE_W-1:0]      r_age   [NUM_SETS][NUM_WAYS];

  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_resp_hit;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr;

  logic [TAG_W-1:0]      w_tag;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_hit;
  logic [AGE_W-1:0]      w_hit_way;
  logic                  w_have_inv;
  logic [AGE_W-1:0]      w_inv_way;
  logic [AGE_W-1:0]      w_lru_way;
  logic [AGE_W-1:0]      w_victim;
  logic [AGE_W-1:0]      w_acc_way;
  logic                  w_touch;

  assign w_tag = r_line[LINE_W-1 -: TAG_W];
  assign w_idx = r_line[IDX_W-1:0];

  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_have_inv = 1'b0;
    w_inv_way  = '0;
    w_lru_way  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!w_hit && r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = AGE_W'(w);
      end
      if (!w_have_inv && !r_valid[w_idx][w]) begin
        w_have_inv = 1'b1;
        w_inv_way  = AGE_W'(w);
      end
      if (r_age[w_idx][w] == AGE_W'(NUM_WAYS - 1)) begin
        w_lru_way = AGE_W'(w);
      end
    end
  end

  assign w_victim  = w_have_inv ? w_inv_way : w_lru_way;
  assign w_acc_way = (r_state == S_LOOKUP) ? w_hit_way : w_victim;
  assign w_touch   = ((r_state == S_LOOKUP) && w_hit) ||
                     ((r_state == S_REFILL) && bus.mem_ack);

`ifdef CACHE_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_line       <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_hit   <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_age[s][w]   <= AGE_W'(w);
        end
      end
`ifdef CACHE_STATS_EN
      r_hit_count  <= '0;
      r_miss_count <= '0;
`endif
    end else begin
      // Ages stay a permutation: only ways younger than the touched one move.
      if (w_touch) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (AGE_W'(w) == w_acc_way) begin
            r_age[w_idx][w] <= '0;
          end else if (r_age[w_idx][w] < r_age[w_idx][w_acc_way]) begin
            r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
          end
        end
      end
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_line      <= bus.req_addr[ADDR_WIDTH-1:OFF_W];
            r_req_ready <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_resp_data  <= r_data[w_idx][w_hit_way];
            r_resp_hit   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
`ifdef CACHE_STATS_EN
            if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
`endif
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {r_line, {OFF_W{1'b0}}};
            r_state    <= S_REFILL;
`ifdef CACHE_STATS_EN
            if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
`endif
          end
        end
        S_REFILL: begin
          if (bus.mem_ack) begin
            r_valid[w_idx][w_victim] <= 1'b1;
            r_tag[w_idx][w_victim]   <= w_tag;
            r_data[w_idx][w_victim]  <= bus.mem_data;
            r_resp_data              <= bus.mem_data;
            r_resp_hit               <= 1'b0;
            r_resp_valid             <= 1'b1;
            r_mem_req                <= 1'b0;
            r_state                  <= S_RESP;
          end
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_hit   = r_resp_hit;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = r_mem_addr;
endmodule

// File: tb/tb_cache_nway_ctrl.sv
// Bench for cache_nway_ctrl: directed scenarios plus random reads against a recency-list cache model.
module tb_cache_nway_ctrl;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int NW = 4;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_nway_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  cache_nway_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(16), .CACHE_SIZE(256), .NUM_WAYS(NW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Model: per set, tags ordered most- to least-recently used.
  logic [4:0] mq [NS][$];

  function automatic logic [DW-1:0] line_word(input logic [AW-1:0] a);
    logic [DW-1:0] l;
    l = DW'(a[AW-1:4]);
    return l * 32'h9E3779B1 + 32'h0BADF00D;
  endfunction

  task automatic mdl_reset();
    for (int s = 0; s < NS; s++) mq[s].delete();
  endtask

  task automatic mdl_access(input logic [AW-1:0] a, output logic hit);
    int idx;
    logic [4:0] tag;
    idx = int'(a[5:4]);
    tag = a[10:6];
    hit = 1'b0;
    for (int i = 0; i < mq[idx].size(); i++) begin
      if (!hit && mq[idx][i] == tag) begin
        hit = 1'b1;
        mq[idx].delete(i);
        break;
      end
    end
    mq[idx].push_front(tag);
    if (mq[idx].size() > NW) void'(mq[idx].pop_back());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_data  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_reset();
  endtask

  // Issues one read from a negedge, acks any refill after ack_dly cycles, ends on a negedge.
  task automatic do_read(input logic [AW-1:0] addr, input int ack_dly, input logic [DW-1:0] fill,
                         output logic hit, output logic [DW-1:0] data, output logic [AW-1:0] maddr,
                         output int lat, output logic ok);
    int n;
    bit done;
    hit = 1'b0; data = '0; maddr = '0; lat = 0; ok = 1'b1; done = 1'b0;
    if (bus.req_ready !== 1'b1) ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 1;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.mem_req !== 1'b0) ok = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.resp_valid === 1'b1) begin
        done = 1'b1; hit = bus.resp_hit; data = bus.resp_data; lat = n;
      end else if (bus.mem_req === 1'b1) begin
        maddr = bus.mem_addr;
        if (n != 2) ok = 1'b0;
        for (int k = 0; k < ack_dly; k++) begin
          @(negedge clk);
          n++;
          if (bus.mem_req !== 1'b1 || bus.mem_addr !== maddr ||
              bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) ok = 1'b0;
        end
        bus.mem_ack  = 1'b1;
        bus.mem_data = fill;
        @(negedge clk);
        n++;
        bus.mem_ack  = 1'b0;
        bus.mem_data = $urandom;
        if (bus.resp_valid !== 1'b1 || bus.mem_req !== 1'b0) ok = 1'b0;
        done = 1'b1; hit = bus.resp_hit; data = bus.resp_data; lat = n;
      end
    end
    if (!done) ok = 1'b0;
    @(negedge clk);
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    checks++; if (bus.resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", bus.resp_data); end
    checks++; if (bus.resp_hit !== 1'b0) begin errors++; $display("FAIL reset_resp_hit: got %b want 0", bus.resp_hit); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    checks++; if (bus.mem_addr !== 11'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
  endtask

  task automatic test_basic();
    logic hit, ok;
    logic [DW-1:0] data;
    logic [AW-1:0] maddr;
    int lat;
    do_reset();
    do_read(11'h000, 1, 32'hDEADBEEF, hit, data, maddr, lat, ok);
    checks++; if (maddr !== 11'h000) begin errors++; $display("FAIL basic_mem_addr: got %h want 000", maddr); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL basic_miss_hit: got %b want 0", hit); end
    checks++; if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_miss_data: got %h want deadbeef", data); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_miss_protocol: got %b want 1", ok); end
    checks++; if (bus.resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data_hold: got %h want deadbeef", bus.resp_data); end
    do_read(11'h004, 0, 32'h0, hit, data, maddr, lat, ok);
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL basic_hit: got %b want 1", hit); end
    checks++; if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_hit_data: got %h want deadbeef", data); end
    checks++; if (lat != 2) begin errors++; $display("FAIL basic_hit_latency: got %0d want 2", lat); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_hit_protocol: got %b want 1", ok); end
  endtask

  task automatic test_lru();
    logic [AW-1:0] seq [8];
    logic          exp_hit [8];
    logic hit, ok;
    logic [DW-1:0] data;
    logic [AW-1:0] maddr;
    int lat;
    seq     = '{11'h000, 11'h040, 11'h080, 11'h0C0, 11'h000, 11'h100, 11'h040, 11'h000};
    exp_hit = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_read(seq[i], 0, line_word(seq[i]), hit, data, maddr, lat, ok);
      checks++; if (hit !== exp_hit[i]) begin errors++; $display("FAIL lru_hit[%0d] addr %h: got %b want %b", i, seq[i], hit, exp_hit[i]); end
      checks++; if (data !== line_word(seq[i])) begin errors++; $display("FAIL lru_data[%0d]: got %h want %h", i, data, line_word(seq[i])); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lru_protocol[%0d]: got %b want 1", i, ok); end
      if (i == 6) begin
        checks++; if (maddr !== 11'h040) begin errors++; $display("FAIL lru_refill_addr: got %h want 040", maddr); end
      end
    end
  endtask

  task automatic test_stall();
    logic hit, ok;
    logic [DW-1:0] data;
    logic [AW-1:0] maddr;
    int lat;
    do_reset();
    do_read(11'h3A8, 10, line_word(11'h3A8), hit, data, maddr, lat, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_stable: got %b want 1", ok); end
    checks++; if (maddr !== 11'h3A0) begin errors++; $display("FAIL stall_mem_addr: got %h want 3a0", maddr); end
    checks++; if (lat != 13) begin errors++; $display("FAIL stall_resp_cycle: got %0d want 13", lat); end
    checks++; if (hit !== 1'b0 || data !== line_word(11'h3A8)) begin errors++; $display("FAIL stall_resp: got hit=%b data=%h want 0/%h", hit, data, line_word(11'h3A8)); end
  endtask

  task automatic test_rst_refill();
    logic hit, ok;
    logic [DW-1:0] data;
    logic [AW-1:0] maddr;
    int lat, seen;
    do_reset();
    bus.req_valid = 1'b1;
    bus.req_addr  = 11'h2C4;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstref_mem_req_up: got %b want 1", bus.mem_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rstref_idle: got mem_req=%b req_ready=%b want 0/1", bus.mem_req, bus.req_ready); end
    bus.mem_ack  = 1'b1;
    bus.mem_data = 32'hCAFE0001;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.resp_valid !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstref_late_ack_resp: got %0d strobes want 0", seen); end
    do_read(11'h2C4, 0, line_word(11'h2C4), hit, data, maddr, lat, ok);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rstref_reread_miss: got %b want 0", hit); end
    checks++; if (data !== line_word(11'h2C4) || ok !== 1'b1) begin errors++; $display("FAIL rstref_reread: got data=%h ok=%b want %h/1", data, ok, line_word(11'h2C4)); end
  endtask

  task automatic test_idle_ack();
    logic hit, ok;
    logic [DW-1:0] data;
    logic [AW-1:0] maddr;
    int lat, bad;
    do_reset();
    do_read(11'h150, 0, line_word(11'h150), hit, data, maddr, lat, ok);
    bad = 0;
    bus.mem_ack  = 1'b1;
    bus.mem_data = 32'hFFFF0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1) bad++;
    end
    bus.mem_ack = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_ack_state: got %0d bad cycles want 0", bad); end
    do_read(11'h15C, 0, 32'h0, hit, data, maddr, lat, ok);
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL idle_ack_hit: got %b want 1", hit); end
    checks++; if (data !== line_word(11'h150)) begin errors++; $display("FAIL idle_ack_data: got %h want %h", data, line_word(11'h150)); end
  endtask

  task automatic test_back_to_back();
    logic hit, ok;
    logic [DW-1:0] data;
    logic [AW-1:0] maddr, a;
    int lat;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = AW'({$urandom_range(0, 31), 2'(i), 4'h0});
      do_read(a, $urandom_range(0, 3), line_word(a), hit, data, maddr, lat, ok);
      do_read(a | 11'h00C, 0, 32'h0, hit, data, maddr, lat, ok);
      checks++; if (hit !== 1'b1 || lat != 2) begin errors++; $display("FAIL b2b_hit[%0d]: got hit=%b lat=%0d want 1/2", i, hit, lat); end
      checks++; if (data !== line_word(a) || ok !== 1'b1) begin errors++; $display("FAIL b2b_data[%0d]: got %h ok=%b want %h/1", i, data, ok, line_word(a)); end
    end
  endtask

  task automatic test_random();
    logic hit, ok, exp_hit;
    logic [DW-1:0] data;
    logic [AW-1:0] maddr, a;
    int lat;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      a = {5'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      mdl_access(a, exp_hit);
      do_read(a, $urandom_range(0, 3), line_word(a), hit, data, maddr, lat, ok);
      checks++; if (hit !== exp_hit) begin errors++; $display("FAIL rand_hit[%0d] addr %h: got %b want %b", i, a, hit, exp_hit); end
      checks++; if (data !== line_word(a)) begin errors++; $display("FAIL rand_data[%0d] addr %h: got %h want %h", i, a, data, line_word(a)); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand_protocol[%0d]: got %b want 1", i, ok); end
      if (!exp_hit) begin
        checks++; if (maddr !== {a[10:4], 4'h0}) begin errors++; $display("FAIL rand_mem_addr[%0d]: got %h want %h", i, maddr, {a[10:4], 4'h0}); end
      end else begin
        checks++; if (lat != 2) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want 2", i, lat); end
      end
    end
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_stats();
    logic hit, ok;
    logic [DW-1:0] data;
    logic [AW-1:0] maddr;
    int lat;
    do_reset();
    checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d/%0d want 0/0", hit_count, miss_count); end
    do_read(11'h000, 0, 32'h1, hit, data, maddr, lat, ok);
    do_read(11'h010, 0, 32'h2, hit, data, maddr, lat, ok);
    do_read(11'h020, 0, 32'h3, hit, data, maddr, lat, ok);
    for (int i = 0; i < 5; i++) do_read(11'h004, 0, 32'h0, hit, data, maddr, lat, ok);
    checks++; if (miss_count !== 16'd3) begin errors++; $display("FAIL stats_miss: got %0d want 3", miss_count); end
    checks++; if (hit_count !== 16'd5) begin errors++; $display("FAIL stats_hit: got %0d want 5", hit_count); end
    dut.r_hit_count = 16'hFFFE;
    do_read(11'h004, 0, 32'h0, hit, data, maddr, lat, ok);
    do_read(11'h004, 0, 32'h0, hit, data, maddr, lat, ok);
    checks++; if (hit_count !== 16'hFFFF) begin errors++; $display("FAIL stats_saturate: got %h want ffff", hit_count); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_lru();
    test_stall();
    test_rst_refill();
    test_idle_ack();
    test_back_to_back();
    test_random();
`ifdef CACHE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
